// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch/MEM request ports and shared SRAM port of the arbiter
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] if_rdata;
  logic [31:0] mem_rdata;
  logic        if_ready;
  logic        mem_ready;
  logic        freeze_if;
  logic        freeze_pipe;
  logic        sram_req;
  logic        sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic        sram_ack;
  logic [31:0] sram_rdata;
  logic        bus_err;

  // master: the arbiter itself; slave: the pipeline and memory around it
  modport master (
    input  if_req, if_addr, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, sram_ack, sram_rdata,
    output if_rdata, mem_rdata, if_ready, mem_ready, freeze_if, freeze_pipe,
           sram_req, sram_we, sram_addr, sram_wdata, bus_err
  );
  modport slave (
    output if_req, if_addr, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, sram_ack, sram_rdata,
    input  if_rdata, mem_rdata, if_ready, mem_ready, freeze_if, freeze_pipe,
           sram_req, sram_we, sram_addr, sram_wdata, bus_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates fetch and MEM-stage accesses onto one single-port SRAM
module mem_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus
);
  typedef enum logic [2:0] {IDLE, BUSY_IF, BUSY_MEM, RESP_IF, RESP_MEM} state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic        mem_req;
  logic        cnt_hit;

  assign mem_req = bus.mem_rd_en | bus.mem_wr_en;
  assign cnt_hit = (cnt_q + 8'd1) == TIMEOUT_C;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      if_rdata_q  <= 32'd0;
      mem_rdata_q <= 32'd0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      we_q        <= we_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    we_d        = we_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        // MEM wins a tie: it belongs to the older instruction in the pipe
        if (mem_req) begin
          state_d = BUSY_MEM;
          addr_d  = bus.mem_addr;
          wdata_d = bus.mem_wdata;
          we_d    = bus.mem_wr_en;
          cnt_d   = 8'd0;
        end else if (bus.if_req) begin
          state_d = BUSY_IF;
          addr_d  = bus.if_addr;
          we_d    = 1'b0;
          cnt_d   = 8'd0;
        end
      end
      BUSY_IF: begin
        if (bus.sram_ack) begin
          if_rdata_d = bus.sram_rdata;
          state_d    = RESP_IF;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_hit) begin
            if_rdata_d = 32'd0;
            err_d      = 1'b1;
            state_d    = RESP_IF;
          end
        end
      end
      BUSY_MEM: begin
        if (bus.sram_ack) begin
          if (!we_q) mem_rdata_d = bus.sram_rdata;
          state_d = RESP_MEM;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_hit) begin
            mem_rdata_d = 32'd0;
            err_d       = 1'b1;
            state_d     = RESP_MEM;
          end
        end
      end
      RESP_IF:  state_d = IDLE;
      RESP_MEM: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  assign bus.sram_req    = (state_q == BUSY_IF) || (state_q == BUSY_MEM);
  assign bus.sram_we     = (state_q == BUSY_MEM) && we_q;
  assign bus.sram_addr   = addr_q;
  assign bus.sram_wdata  = wdata_q;
  assign bus.if_ready    = (state_q == RESP_IF);
  assign bus.mem_ready   = (state_q == RESP_MEM);
  assign bus.if_rdata    = if_rdata_q;
  assign bus.mem_rdata   = mem_rdata_q;
  assign bus.bus_err     = err_q;
  assign bus.freeze_if   = bus.if_req & ~bus.if_ready;
  assign bus.freeze_pipe = mem_req & ~bus.mem_ready;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a behavioural SRAM
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if bus();
  mem_arbiter #(.TIMEOUT(15)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    bit          is_mem;
    logic [31:0] rdata;
  } resp_t;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] mem [logic [31:0]];
  int          ack_lat = 0;
  bit          no_ack = 1'b0;
  bit          force_ack = 1'b0;
  logic [31:0] grant_addr [$];
  logic        grant_we [$];
  logic [31:0] grant_wdata [$];
  resp_t       exp_q [$];

  // SRAM model: acks ack_lat cycles into a BUSY phase, applies writes at the ack
  initial begin : responder
    int busy_cnt;
    busy_cnt = 0;
    bus.sram_ack = 1'b0;
    bus.sram_rdata = 32'd0;
    forever begin
      @(posedge clk); #1;
      if (bus.sram_req) begin
        if (!no_ack && busy_cnt == ack_lat) begin
          bus.sram_ack = 1'b1;
          if (bus.sram_we) begin
            mem[bus.sram_addr] = bus.sram_wdata;
            bus.sram_rdata = 32'hDEAD_BEEF;
          end else begin
            bus.sram_rdata = mem.exists(bus.sram_addr) ? mem[bus.sram_addr] : 32'd0;
          end
        end else begin
          bus.sram_ack = 1'b0;
          bus.sram_rdata = $urandom;
        end
        busy_cnt++;
      end else begin
        busy_cnt = 0;
        bus.sram_ack = force_ack;
        bus.sram_rdata = 32'hBAD0_0000 | 32'($urandom_range(0, 255));
      end
    end
  end

  initial begin : monitor
    logic prev;
    prev = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus.sram_req && !prev) begin
        grant_addr.push_back(bus.sram_addr);
        grant_we.push_back(bus.sram_we);
        grant_wdata.push_back(bus.sram_wdata);
      end
      prev = bus.sram_req;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    bus.if_req = 1'b0; bus.if_addr = 32'd0;
    bus.mem_rd_en = 1'b0; bus.mem_wr_en = 1'b0;
    bus.mem_addr = 32'd0; bus.mem_wdata = 32'd0;
  endtask

  task automatic clear_log();
    grant_addr.delete(); grant_we.delete(); grant_wdata.delete();
  endtask

  task automatic wait_any(input int limit, output int cyc, output bit ok);
    cyc = 0; ok = 1'b0;
    while (cyc < limit && !ok) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.if_ready || bus.mem_ready) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.if_req = 1'b1; bus.if_addr = 32'h44;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.sram_req !== 1'b0) begin errors++; $display("FAIL reset_sram_req got=%b exp=0", bus.sram_req); end
    checks++; if (bus.sram_we !== 1'b0) begin errors++; $display("FAIL reset_sram_we got=%b exp=0", bus.sram_we); end
    checks++; if (bus.if_ready !== 1'b0 || bus.mem_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b%b exp=00", bus.if_ready, bus.mem_ready); end
    checks++; if (bus.bus_err !== 1'b0) begin errors++; $display("FAIL reset_bus_err got=%b exp=0", bus.bus_err); end
    checks++; if (bus.sram_addr !== 32'd0 || bus.sram_wdata !== 32'd0) begin errors++; $display("FAIL reset_sram_bus got=%h/%h exp=0/0", bus.sram_addr, bus.sram_wdata); end
    checks++; if (bus.if_rdata !== 32'd0 || bus.mem_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got=%h/%h exp=0/0", bus.if_rdata, bus.mem_rdata); end
    checks++; if (bus.freeze_if !== 1'b1 || bus.freeze_pipe !== 1'b0) begin errors++; $display("FAIL reset_freeze got=%b%b exp=10", bus.freeze_if, bus.freeze_pipe); end
    bus.if_req = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fetch();
    resp_t e;
    int cyc;
    bit ok;
    mem[32'h8] = 32'hE3A00014;
    ack_lat = 1; no_ack = 1'b0;
    clear_log();
    exp_q.push_back('{1'b0, 32'hE3A00014});
    bus.if_req = 1'b1; bus.if_addr = 32'h8;
    #1;
    checks++; if (bus.freeze_if !== 1'b1) begin errors++; $display("FAIL fetch_freeze_start got=%b exp=1", bus.freeze_if); end
    cyc = 0; ok = 1'b0;
    while (cyc < 40 && !ok) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.if_ready) ok = 1'b1;
      else begin
        checks++; if (bus.freeze_if !== 1'b1) begin errors++; $display("FAIL fetch_freeze_wait got=%b exp=1", bus.freeze_if); end
      end
    end
    checks++; if (!ok) begin errors++; $display("FAIL fetch_timeout got=no_ready exp=if_ready"); end
    checks++; if (cyc !== 3) begin errors++; $display("FAIL fetch_latency got=%0d exp=3", cyc); end
    e = exp_q.pop_front();
    checks++; if (bus.if_rdata !== e.rdata) begin errors++; $display("FAIL fetch_rdata got=%h exp=%h", bus.if_rdata, e.rdata); end
    checks++; if (bus.freeze_if !== 1'b0) begin errors++; $display("FAIL fetch_freeze_end got=%b exp=0", bus.freeze_if); end
    checks++; if (grant_addr.size() != 1 || grant_addr[0] !== 32'h8) begin errors++; $display("FAIL fetch_sram_addr got=%0d grants exp=1 grant at 00000008", grant_addr.size()); end
    bus.if_req = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.if_ready !== 1'b0) begin errors++; $display("FAIL fetch_ready_pulse got=%b exp=0", bus.if_ready); end
  endtask

  task automatic test_contention();
    resp_t e;
    int cyc;
    bit ok;
    mem[32'h400] = 32'h11223344;
    mem[32'h10]  = 32'hAABBCCDD;
    ack_lat = 0;
    clear_log();
    exp_q.push_back('{1'b1, 32'h11223344});
    exp_q.push_back('{1'b0, 32'hAABBCCDD});
    bus.if_req = 1'b1; bus.if_addr = 32'h10;
    bus.mem_rd_en = 1'b1; bus.mem_addr = 32'h400;
    #1;
    checks++; if (bus.freeze_pipe !== 1'b1) begin errors++; $display("FAIL cont_freeze_pipe got=%b exp=1", bus.freeze_pipe); end
    for (int k = 0; k < 2; k++) begin
      wait_any(40, cyc, ok);
      e = exp_q.pop_front();
      checks++; if (!ok || bus.mem_ready !== e.is_mem || bus.if_ready !== !e.is_mem) begin
        errors++; $display("FAIL cont_order%0d got=if%b/mem%b exp_mem=%0d", k, bus.if_ready, bus.mem_ready, e.is_mem);
      end
      checks++; if ((e.is_mem ? bus.mem_rdata : bus.if_rdata) !== e.rdata) begin
        errors++; $display("FAIL cont_rdata%0d got=%h exp=%h", k, e.is_mem ? bus.mem_rdata : bus.if_rdata, e.rdata);
      end
      checks++; if (cyc !== (k == 0 ? 2 : 3)) begin errors++; $display("FAIL cont_latency%0d got=%0d exp=%0d", k, cyc, k == 0 ? 2 : 3); end
      if (e.is_mem) bus.mem_rd_en = 1'b0; else bus.if_req = 1'b0;
    end
    checks++; if (grant_addr.size() != 2 || grant_addr[0] !== 32'h400 || grant_addr[1] !== 32'h10) begin
      errors++; $display("FAIL cont_grant_order got=%0d grants exp=00000400 then 00000010", grant_addr.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_store();
    resp_t e;
    int cyc;
    bit ok;
    ack_lat = 0;
    clear_log();
    // write: mem_rdata keeps the last load value
    exp_q.push_back('{1'b1, 32'h11223344});
    bus.mem_wr_en = 1'b1; bus.mem_addr = 32'h400; bus.mem_wdata = 32'h2000;
    wait_any(40, cyc, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || bus.mem_ready !== 1'b1) begin errors++; $display("FAIL store_ready got=%b exp=1", bus.mem_ready); end
    checks++; if (bus.mem_rdata !== e.rdata) begin errors++; $display("FAIL store_rdata_hold got=%h exp=%h", bus.mem_rdata, e.rdata); end
    checks++; if (grant_we.size() != 1 || grant_we[0] !== 1'b1 || grant_wdata[0] !== 32'h2000) begin
      errors++; $display("FAIL store_sram_we_wdata got=%0d grants exp=1 write of 00002000", grant_we.size());
    end
    bus.mem_wr_en = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back('{1'b1, 32'h2000});
    bus.mem_rd_en = 1'b1; bus.mem_addr = 32'h400;
    wait_any(40, cyc, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || bus.mem_rdata !== e.rdata) begin errors++; $display("FAIL store_readback got=%h exp=%h", bus.mem_rdata, e.rdata); end
    bus.mem_rd_en = 1'b0;
    @(posedge clk); #1;
    clear_log();
    exp_q.push_back('{1'b1, 32'h2000});
    bus.mem_rd_en = 1'b1; bus.mem_wr_en = 1'b1; bus.mem_addr = 32'h404; bus.mem_wdata = 32'h77;
    wait_any(40, cyc, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || bus.mem_rdata !== e.rdata) begin errors++; $display("FAIL rdwr_rdata_hold got=%h exp=%h", bus.mem_rdata, e.rdata); end
    checks++; if (grant_we.size() != 1 || grant_we[0] !== 1'b1) begin errors++; $display("FAIL rdwr_as_write got=%0d grants exp=1 write", grant_we.size()); end
    checks++; if (!mem.exists(32'h404) || mem[32'h404] !== 32'h77) begin errors++; $display("FAIL rdwr_mem_content exp=00000077 at 00000404"); end
    idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    resp_t e;
    int cyc;
    bit ok;
    checks++; if (bus.bus_err !== 1'b0) begin errors++; $display("FAIL timeout_err_before got=%b exp=0", bus.bus_err); end
    no_ack = 1'b1;
    exp_q.push_back('{1'b1, 32'h0});
    bus.mem_rd_en = 1'b1; bus.mem_addr = 32'h20;
    wait_any(60, cyc, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || bus.mem_ready !== 1'b1) begin errors++; $display("FAIL timeout_ready got=%b exp=1", bus.mem_ready); end
    checks++; if (cyc !== 16) begin errors++; $display("FAIL timeout_latency got=%0d exp=16", cyc); end
    checks++; if (bus.mem_rdata !== e.rdata) begin errors++; $display("FAIL timeout_rdata got=%h exp=%h", bus.mem_rdata, e.rdata); end
    checks++; if (bus.bus_err !== 1'b1) begin errors++; $display("FAIL timeout_err_set got=%b exp=1", bus.bus_err); end
    bus.mem_rd_en = 1'b0;
    no_ack = 1'b0; ack_lat = 0;
    @(posedge clk); #1;
    exp_q.push_back('{1'b0, 32'hE3A00014});
    bus.if_req = 1'b1; bus.if_addr = 32'h8;
    wait_any(40, cyc, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || bus.if_rdata !== e.rdata || cyc !== 2) begin errors++; $display("FAIL timeout_next_access got=%h in %0d exp=%h in 2", bus.if_rdata, cyc, e.rdata); end
    checks++; if (bus.bus_err !== 1'b1) begin errors++; $display("FAIL timeout_err_sticky got=%b exp=1", bus.bus_err); end
    bus.if_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    resp_t e;
    int cyc;
    bit ok;
    ack_lat = 0;
    clear_log();
    exp_q.push_back('{1'b0, 32'hAABBCCDD});
    exp_q.push_back('{1'b0, 32'hAABBCCDD});
    bus.if_req = 1'b1; bus.if_addr = 32'h10;
    for (int k = 0; k < 2; k++) begin
      wait_any(40, cyc, ok);
      e = exp_q.pop_front();
      checks++; if (!ok || bus.if_ready !== 1'b1 || bus.if_rdata !== e.rdata) begin errors++; $display("FAIL b2b_resp%0d got=%h exp=%h", k, bus.if_rdata, e.rdata); end
      checks++; if (cyc !== (k == 0 ? 2 : 3)) begin errors++; $display("FAIL b2b_latency%0d got=%0d exp=%0d", k, cyc, k == 0 ? 2 : 3); end
    end
    bus.if_req = 1'b0;
    checks++; if (grant_addr.size() != 2) begin errors++; $display("FAIL b2b_grants got=%0d exp=2", grant_addr.size()); end
    @(posedge clk); #1;
  endtask

  task automatic test_spurious_ack();
    idle_inputs();
    force_ack = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      checks++; if (bus.if_ready !== 1'b0 || bus.mem_ready !== 1'b0 || bus.sram_req !== 1'b0) begin
        errors++; $display("FAIL spurious_ack got=if%b/mem%b/req%b exp=0/0/0", bus.if_ready, bus.mem_ready, bus.sram_req);
      end
    end
    checks++; if (bus.if_rdata !== 32'hAABBCCDD) begin errors++; $display("FAIL spurious_rdata got=%h exp=aabbccdd", bus.if_rdata); end
    force_ack = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    resp_t e;
    int cyc;
    bit ok;
    no_ack = 1'b1;
    bus.mem_rd_en = 1'b1; bus.mem_addr = 32'h30;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.sram_req !== 1'b1) begin errors++; $display("FAIL rstmid_busy got=%b exp=1", bus.sram_req); end
    rst = 1'b1;
    #1;
    checks++; if (bus.sram_req !== 1'b0) begin errors++; $display("FAIL rstmid_req_drop got=%b exp=0", bus.sram_req); end
    checks++; if (bus.bus_err !== 1'b0) begin errors++; $display("FAIL rstmid_err_clear got=%b exp=0", bus.bus_err); end
    bus.mem_rd_en = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      checks++; if (bus.mem_ready !== 1'b0) begin errors++; $display("FAIL rstmid_no_ready got=%b exp=0", bus.mem_ready); end
    end
    no_ack = 1'b0; ack_lat = 0;
    clear_log();
    exp_q.push_back('{1'b1, 32'h2000});
    bus.mem_rd_en = 1'b1; bus.mem_addr = 32'h400;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.sram_req !== 1'b1 || bus.sram_addr !== 32'h400) begin errors++; $display("FAIL rstmid_first_grant got=%b/%h exp=1/00000400", bus.sram_req, bus.sram_addr); end
    wait_any(40, cyc, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || bus.mem_ready !== 1'b1 || bus.mem_rdata !== e.rdata || cyc !== 1) begin
      errors++; $display("FAIL rstmid_next_access got=%h in %0d exp=%h in 1", bus.mem_rdata, cyc, e.rdata);
    end
    bus.mem_rd_en = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fetch();
    test_contention();
    test_store();
    test_timeout();
    test_back_to_back();
    test_spurious_ack();
    test_reset_mid();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
